alu_16: RTL and testbench
=========================

Name: alu_16

Overview:
- Registered 16-bit ALU with 32 operations selected by a 5-bit opcode.
- Two 16-bit operands arrive packed in one 32-bit word.
- The 32-bit packed result holds either a 16-bit result plus flags, or a full 32-bit wide result.
- Used as a standalone datapath block; one operation accepted per clock, no handshake.

Parameters:
- None. Widths are fixed: 16-bit operands, 32-bit packed buses.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- packed_in  input  32  operand A = [31:16], operand B = [15:0].
- selection_lines  input  5  opcode.
- packed_out  output  32  registered result word.

Behaviour:
- Reset: rst_n low at a rising clk edge sets packed_out = 32'h0000_0000. rst_n is sampled only at clk edges.
- Latency: the result is computed combinationally from packed_in and selection_lines, and registered on every rising clk edge (rst_n high). packed_out is valid 1 cycle after the inputs are sampled. Inputs change every cycle freely.
- Narrow ops (all except 20, 21, 22):
  - packed_out[15:0] = result R.
  - packed_out[31:20] = 0.
  - [19] N = R[15]; [18] Z = (R == 0); [17] C; [16] V.
  - C and V are 0 unless listed below.
- Opcodes:
  - 0 ADD: A+B; C = carry out, V = signed overflow.
  - 1 SUB: A-B; C = borrow (A<B unsigned), V = signed overflow.
  - 2 RSB: B-A; C and V as SUB with operands swapped.
  - 3 INC A: C = (A == FFFF), V = (A == 7FFF).
  - 4 DEC A: C = (A == 0), V = (A == 8000).
  - 5 NEG A: 0-A; C = (A != 0), V = (A == 8000).
  - 6 AND. 7 OR. 8 XOR. 9 NAND. 10 NOR. 11 XNOR. 12 NOT A. 13 PASS A. 14 PASS B.
  - Shifts use amount s = B[3:0]; C = last bit shifted out, and C = 0 when s = 0.
    - 15 SHL A.
    - 16 SHR logical.
    - 17 SAR arithmetic.
    - 18 ROL.
    - 19 ROR. For rotates C = 0.
  - 20 MULU: packed_out = A*B, 32-bit unsigned.
  - 21 MULS: packed_out = A*B, 32-bit signed two's complement.
  - 22 DIVU: [15:0] = A/B, [31:16] = A%B, unsigned. If B = 0: quotient FFFF, remainder A.
  - 23 EQ: R = (A == B) ? 1 : 0.
  - 24 SLTU: R = (A < B) ? 1 : 0, unsigned.
  - 25 SLT: R = (A < B) ? 1 : 0, signed.
  - 26 MINU. 27 MAXU. 28 MINS. 29 MAXS.
  - 30 ABS A: ABS(8000) = 8000 with V = 1.
  - 31 CLZ A: count leading zeros; A = 0 gives 16.
- Wide ops 20–22 carry no flags.
- No internal state besides the output register; there is no carry-in.

Optional Feature:
- Macro: ALU16_DIV_EN.
- Defined: opcode 22 implemented as above, as a purely combinational divider in the same single cycle.
- Undefined: no divider logic; opcode 22 yields packed_out = 0.
- All other opcodes are unaffected either way.

Decomposition:
- Package alu_16_pkg holds:
  - the 5-bit opcode localparams (OP_ADD = 0 … OP_CLZ = 31);
  - flag bit positions (FLAG_N = 19, FLAG_Z = 18, FLAG_C = 17, FLAG_V = 16);
  - the operand-width constant 16.
- One natural sub-module, alu_16_shifter: combinational SHL/SHR/SAR/ROL/ROR with carry-out. The top holds the opcode mux and output register.

Test Plan:
- Reset: rst_n = 0 for one edge with any inputs -> packed_out = 0000_0000. Release -> next edge shows a computed value.
- ADD overflow: A = 7FFF, B = 0001, op 0 -> packed_out = 0009_8000 (N = 1, V = 1). A = FFFF, B = 0001 -> 0006_0000 (Z = 1, C = 1).
- MULS: A = FFFE, B = 0003, op 21 -> FFFF_FFFA. MULU with the same operands, op 20 -> 0002_FFFA.
- DIVU: A = 0064, B = 0007, op 22 -> 0002_000E. B = 0 -> 0064_FFFF. With ALU16_DIV_EN undefined -> 0000_0000.
- Shifts: A = 8001, B = 0001:
  - op 17 SAR -> 000A_C000 (N = 1, C = 1).
  - op 15 SHL -> 0002_0002 (C = 1).
  - op 18 ROL -> 0000_0003.
- Latency/back-to-back: change opcode every cycle over all 32 values with random operands; each packed_out equals the golden model of the inputs sampled one edge earlier. Also run op 31 on A = 0 -> 0000_0010.

Source files
------------

// File: rtl/alu_16_pkg.sv
// Shared constants for the alu_16 datapath: opcode encodings, flag bit
// positions, operand width, shifter operation encoding and a CLZ helper.
package alu_16_pkg;

  localparam int unsigned DATA_W = 16;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_RSB  = 5'd2;
  localparam logic [4:0] OP_INC  = 5'd3;
  localparam logic [4:0] OP_DEC  = 5'd4;
  localparam logic [4:0] OP_NEG  = 5'd5;
  localparam logic [4:0] OP_AND  = 5'd6;
  localparam logic [4:0] OP_OR   = 5'd7;
  localparam logic [4:0] OP_XOR  = 5'd8;
  localparam logic [4:0] OP_NAND = 5'd9;
  localparam logic [4:0] OP_NOR  = 5'd10;
  localparam logic [4:0] OP_XNOR = 5'd11;
  localparam logic [4:0] OP_NOT  = 5'd12;
  localparam logic [4:0] OP_PASA = 5'd13;
  localparam logic [4:0] OP_PASB = 5'd14;
  localparam logic [4:0] OP_SHL  = 5'd15;
  localparam logic [4:0] OP_SHR  = 5'd16;
  localparam logic [4:0] OP_SAR  = 5'd17;
  localparam logic [4:0] OP_ROL  = 5'd18;
  localparam logic [4:0] OP_ROR  = 5'd19;
  localparam logic [4:0] OP_MULU = 5'd20;
  localparam logic [4:0] OP_MULS = 5'd21;
  localparam logic [4:0] OP_DIVU = 5'd22;
  localparam logic [4:0] OP_EQ   = 5'd23;
  localparam logic [4:0] OP_SLTU = 5'd24;
  localparam logic [4:0] OP_SLT  = 5'd25;
  localparam logic [4:0] OP_MINU = 5'd26;
  localparam logic [4:0] OP_MAXU = 5'd27;
  localparam logic [4:0] OP_MINS = 5'd28;
  localparam logic [4:0] OP_MAXS = 5'd29;
  localparam logic [4:0] OP_ABS  = 5'd30;
  localparam logic [4:0] OP_CLZ  = 5'd31;

  localparam int unsigned FLAG_N = 19;
  localparam int unsigned FLAG_Z = 18;
  localparam int unsigned FLAG_C = 17;
  localparam int unsigned FLAG_V = 16;

  typedef enum logic [2:0] {
    SH_SHL,
    SH_SHR,
    SH_SAR,
    SH_ROL,
    SH_ROR
  } shift_op_e;

  // Leading-zero count; an all-zero word yields DATA_W.
  function automatic logic [4:0] clz16(input logic [DATA_W-1:0] x);
    logic [4:0] n;
    logic       found;
    n     = '0;
    found = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (x[i]) found = 1'b1;
        else      n = n + 5'd1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/alu_16_shifter.sv
// Combinational 16-bit shifter/rotator with carry-out of the last bit
// shifted out (zero for a zero amount and for rotates).
module alu_16_shifter
  import alu_16_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [3:0]        amt_i,
  input  shift_op_e         op_i,
  output logic [DATA_W-1:0] res_o,
  output logic              carry_o
);

  logic [4:0] rot_back;

  assign rot_back = 5'd16 - {1'b0, amt_i};

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    res_o   = a_i;
    carry_o = 1'b0;
    case (op_i)
      // A guard bit beside the word catches the last bit shifted out.
      SH_SHL: {carry_o, res_o} = {1'b0, a_i} << amt_i;
      SH_SHR: {res_o, carry_o} = {a_i, 1'b0} >> amt_i;
      SH_SAR: {res_o, carry_o} = $signed({a_i, 1'b0}) >>> amt_i;
      SH_ROL: res_o = (a_i << amt_i) | (a_i >> rot_back);
      SH_ROR: res_o = (a_i >> amt_i) | (a_i << rot_back);
      default: begin
        res_o   = a_i;
        carry_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_16.sv
// Registered 16-bit ALU, 32 opcodes, one operation per clock.
// Optional single-cycle unsigned divider on opcode 22 when ALU16_DIV_EN is defined.
module alu_16
  import alu_16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] packed_in,
  input  logic [4:0]  selection_lines,
  output logic [31:0] packed_out
);

  logic [DATA_W-1:0] a, b;
  logic [16:0]       add_w, sub_w, rsb_w;
  logic [31:0]       mulu_w, muls_w;
  logic              slt_w;
  logic [DATA_W-1:0] abs_w;

  shift_op_e         sh_op;
  logic [DATA_W-1:0] sh_res;
  logic              sh_carry;

  logic [DATA_W-1:0] res;
  logic              flag_c, flag_v;
  logic              wide;
  logic [31:0]       wide_res;
  logic [31:0]       packed_d, packed_q;

  assign a = packed_in[31:16];
  assign b = packed_in[15:0];

  // Borrow is the 17th bit of the zero-extended difference.
  assign add_w  = {1'b0, a} + {1'b0, b};
  assign sub_w  = {1'b0, a} - {1'b0, b};
  assign rsb_w  = {1'b0, b} - {1'b0, a};
  assign mulu_w = {16'b0, a} * {16'b0, b};
  assign muls_w = {{16{a[15]}}, a} * {{16{b[15]}}, b};
  assign slt_w  = $signed(a) < $signed(b);
  assign abs_w  = a[15] ? (16'd0 - a) : a;

`ifdef ALU16_DIV_EN
  logic [DATA_W-1:0] quo_w, rem_w;

  assign quo_w = (b == '0) ? '1 : (a / b);
  assign rem_w = (b == '0) ? a  : (a % b);
`endif

  always_comb begin
    sh_op = SH_SHL;
    case (selection_lines)
      OP_SHR:  sh_op = SH_SHR;
      OP_SAR:  sh_op = SH_SAR;
      OP_ROL:  sh_op = SH_ROL;
      OP_ROR:  sh_op = SH_ROR;
      default: sh_op = SH_SHL;
    endcase
  end

  alu_16_shifter u_shifter (
    .a_i    (a),
    .amt_i  (b[3:0]),
    .op_i   (sh_op),
    .res_o  (sh_res),
    .carry_o(sh_carry)
  );

  always_comb begin
    res      = '0;
    flag_c   = 1'b0;
    flag_v   = 1'b0;
    wide     = 1'b0;
    wide_res = '0;
    case (selection_lines)
      OP_ADD: begin
        res    = add_w[15:0];
        flag_c = add_w[16];
        flag_v = (a[15] == b[15]) && (add_w[15] != a[15]);
      end
      OP_SUB: begin
        res    = sub_w[15:0];
        flag_c = sub_w[16];
        flag_v = (a[15] != b[15]) && (sub_w[15] != a[15]);
      end
      OP_RSB: begin
        res    = rsb_w[15:0];
        flag_c = rsb_w[16];
        flag_v = (a[15] != b[15]) && (rsb_w[15] != b[15]);
      end
      OP_INC: begin
        res    = a + 16'd1;
        flag_c = (a == 16'hFFFF);
        flag_v = (a == 16'h7FFF);
      end
      OP_DEC: begin
        res    = a - 16'd1;
        flag_c = (a == 16'h0000);
        flag_v = (a == 16'h8000);
      end
      OP_NEG: begin
        res    = 16'd0 - a;
        flag_c = (a != 16'h0000);
        flag_v = (a == 16'h8000);
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NAND: res = ~(a & b);
      OP_NOR:  res = ~(a | b);
      OP_XNOR: res = ~(a ^ b);
      OP_NOT:  res = ~a;
      OP_PASA: res = a;
      OP_PASB: res = b;
      OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR: begin
        res    = sh_res;
        flag_c = sh_carry;
      end
      OP_MULU: begin
        wide     = 1'b1;
        wide_res = mulu_w;
      end
      OP_MULS: begin
        wide     = 1'b1;
        wide_res = muls_w;
      end
      OP_DIVU: begin
        wide = 1'b1;
`ifdef ALU16_DIV_EN
        wide_res = {rem_w, quo_w};
`else
        wide_res = '0;
`endif
      end
      OP_EQ:   res = {15'd0, a == b};
      OP_SLTU: res = {15'd0, a < b};
      OP_SLT:  res = {15'd0, slt_w};
      OP_MINU: res = (a < b) ? a : b;
      OP_MAXU: res = (a < b) ? b : a;
      OP_MINS: res = slt_w ? a : b;
      OP_MAXS: res = slt_w ? b : a;
      OP_ABS: begin
        res    = abs_w;
        flag_v = (a == 16'h8000);
      end
      OP_CLZ:  res = {11'd0, clz16(a)};
      default: res = '0;
    endcase
  end

  always_comb begin
    packed_d = '0;
    if (wide) begin
      packed_d = wide_res;
    end else begin
      packed_d[15:0]   = res;
      packed_d[FLAG_N] = res[15];
      packed_d[FLAG_Z] = (res == '0);
      packed_d[FLAG_C] = flag_c;
      packed_d[FLAG_V] = flag_v;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (!rst_n) packed_q <= '0;
    else        packed_q <= packed_d;
  end

  assign packed_out = packed_q;

endmodule

// File: tb/tb_alu_16.sv
// Self-checking bench for alu_16: directed vector table, reset and latency
// sequences, and randomized back-to-back operations against a reference model.
module tb_alu_16;
  import alu_16_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] packed_in;
  logic [4:0]  selection_lines;
  logic [31:0] packed_out;

  int checks   = 0;
  int failures = 0;

  alu_16 dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .packed_in      (packed_in),
    .selection_lines(selection_lines),
    .packed_out     (packed_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model written from the arithmetic definitions with plain integers.
  function automatic logic [31:0] model(input logic [4:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int s  = int'(b[3:0]);
    int t;
    longint p;
    logic [15:0] r = '0;
    logic c = 1'b0;
    logic v = 1'b0;
    case (op)
      5'd0: begin t = ua + ub; r = 16'(t); c = t > 65535;
                  v = (sa + sb > 32767) || (sa + sb < -32768); end
      5'd1: begin r = 16'(ua - ub); c = ua < ub;
                  v = (sa - sb > 32767) || (sa - sb < -32768); end
      5'd2: begin r = 16'(ub - ua); c = ub < ua;
                  v = (sb - sa > 32767) || (sb - sa < -32768); end
      5'd3: begin r = 16'(ua + 1); c = ua == 65535; v = sa == 32767; end
      5'd4: begin r = 16'(ua - 1); c = ua == 0; v = sa == -32768; end
      5'd5: begin r = 16'(-ua); c = ua != 0; v = sa == -32768; end
      5'd6:  r = a & b;
      5'd7:  r = a | b;
      5'd8:  r = a ^ b;
      5'd9:  r = ~(a & b);
      5'd10: r = ~(a | b);
      5'd11: r = ~(a ^ b);
      5'd12: r = ~a;
      5'd13: r = a;
      5'd14: r = b;
      5'd15: begin r = 16'(ua * (1 << s));
                   c = (s != 0) && (((ua >> (16 - s)) & 1) != 0); end
      5'd16: begin r = 16'(ua / (1 << s));
                   c = (s != 0) && (((ua >> (s - 1)) & 1) != 0); end
      5'd17: begin r = 16'(sa >>> s);
                   c = (s != 0) && (((ua >> (s - 1)) & 1) != 0); end
      5'd18: r = 16'((ua << s) | (ua >> (16 - s)));
      5'd19: r = 16'((ua >> s) | (ua << (16 - s)));
      5'd20: begin p = longint'(ua) * longint'(ub); return 32'(p); end
      5'd21: begin p = longint'(sa) * longint'(sb); return 32'(p); end
      5'd22: begin
`ifdef ALU16_DIV_EN
        if (ub == 0) return {a, 16'hFFFF};
        return {16'(ua % ub), 16'(ua / ub)};
`else
        return 32'h0;
`endif
      end
      5'd23: r = (ua == ub) ? 16'd1 : 16'd0;
      5'd24: r = (ua < ub) ? 16'd1 : 16'd0;
      5'd25: r = (sa < sb) ? 16'd1 : 16'd0;
      5'd26: r = (ua < ub) ? a : b;
      5'd27: r = (ua > ub) ? a : b;
      5'd28: r = (sa < sb) ? a : b;
      5'd29: r = (sa > sb) ? a : b;
      5'd30: begin r = (sa < 0) ? 16'(-sa) : a; v = sa == -32768; end
      default: begin
        t = 0;
        while (t < 16 && a[15 - t] == 1'b0) t++;
        r = 16'(t);
      end
    endcase
    return {12'h000, r[15], r == 16'h0, c, v, r};
  endfunction

  task automatic apply(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    selection_lines = op;
    packed_in       = {a, b};
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h7FFF;
      2: return 16'h8000;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  vec_t        vecs[$];
  logic [31:0] exp_prev;
  logic [4:0]  op_r;
  logic [15:0] a_r, b_r;

  initial begin
    rst_n           = 1'b1;
    packed_in       = 32'h1234_5678;
    selection_lines = OP_ADD;

    // Reset with arbitrary inputs.
    @(negedge clk);
    rst_n = 1'b0;
    packed_in = 32'hFFFF_0001;
    @(posedge clk);
    #1;
    check("reset_clears", packed_out, 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", packed_out, 32'h0006_0000);

    vecs.push_back('{OP_ADD,  16'h7FFF, 16'h0001, 32'h0009_8000, "add_ovf"});
    vecs.push_back('{OP_ADD,  16'hFFFF, 16'h0001, 32'h0006_0000, "add_carry"});
    vecs.push_back('{OP_MULS, 16'hFFFE, 16'h0003, 32'hFFFF_FFFA, "muls"});
    vecs.push_back('{OP_MULU, 16'hFFFE, 16'h0003, 32'h0002_FFFA, "mulu"});
`ifdef ALU16_DIV_EN
    vecs.push_back('{OP_DIVU, 16'h0064, 16'h0007, 32'h0002_000E, "divu"});
    vecs.push_back('{OP_DIVU, 16'h0064, 16'h0000, 32'h0064_FFFF, "divu_by0"});
`else
    vecs.push_back('{OP_DIVU, 16'h0064, 16'h0007, 32'h0000_0000, "divu_off"});
    vecs.push_back('{OP_DIVU, 16'h0064, 16'h0000, 32'h0000_0000, "divu_off_by0"});
`endif
    vecs.push_back('{OP_SAR,  16'h8001, 16'h0001, 32'h000A_C000, "sar"});
    vecs.push_back('{OP_SHL,  16'h8001, 16'h0001, 32'h0002_0002, "shl"});
    vecs.push_back('{OP_ROL,  16'h8001, 16'h0001, 32'h0000_0003, "rol"});
    vecs.push_back('{OP_CLZ,  16'h0000, 16'h1234, 32'h0000_0010, "clz_zero"});
    vecs.push_back('{OP_SHR,  16'h8001, 16'h0000, 32'h0008_8001, "shr_zero_amt"});
    vecs.push_back('{OP_ABS,  16'h8000, 16'h0000, 32'h0009_8000, "abs_min"});
    vecs.push_back('{OP_NEG,  16'h0000, 16'h0000, 32'h0004_0000, "neg_zero"});
    vecs.push_back('{OP_SUB,  16'h0001, 16'h0002, 32'h000A_FFFF, "sub_borrow"});
    vecs.push_back('{OP_SLT,  16'hFFFF, 16'h0001, 32'h0000_0001, "slt_signed"});
    vecs.push_back('{OP_SLTU, 16'hFFFF, 16'h0001, 32'h0004_0000, "sltu"});
    vecs.push_back('{OP_DEC,  16'h8000, 16'h0000, 32'h0001_7FFF, "dec_ovf"});

    foreach (vecs[i]) begin
      apply(vecs[i].op, vecs[i].a, vecs[i].b);
      check(vecs[i].name, packed_out, vecs[i].exp);
    end

    // Reset is sampled only at the edge: asserting it mid-cycle holds the output.
    apply(OP_PASA, 16'hABCD, 16'h0000);
    rst_n = 1'b0;
    #2;
    check("reset_sync_hold", packed_out, 32'h0008_ABCD);
    @(posedge clk);
    #1;
    check("reset_midstream", packed_out, 32'h0000_0000);
    rst_n = 1'b1;

    // Back-to-back: new inputs land right after each edge; the output must
    // still show the operation sampled on that edge.
    @(posedge clk);
    #1;
    op_r = 5'd0; a_r = pick_operand(); b_r = pick_operand();
    selection_lines = op_r;
    packed_in = {a_r, b_r};
    exp_prev = model(op_r, a_r, b_r);
    for (int n = 1; n <= 32 * 12; n++) begin
      @(posedge clk);
      #1;
      op_r = 5'(n % 32);
      a_r  = pick_operand();
      b_r  = pick_operand();
      selection_lines = op_r;
      packed_in = {a_r, b_r};
      #1;
      check($sformatf("b2b_op%0d", (n + 31) % 32), packed_out, exp_prev);
      exp_prev = model(op_r, a_r, b_r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
